// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory request arbiter.
//   state_t      - arbiter FSM states
//   SZ_*         - size codes passed to the APB bridge (SZ_LINE marks a line fill)
//   line_addr_w  - width of the line-address field for a given address/line size
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_ISSUE = 3'd1,
    ST_WR_WAIT  = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_FILL_RSP = 3'd5
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_LINE = 2'b11;

  function automatic int line_addr_w(input int addr_w, input int line_bytes);
    return addr_w - $clog2(line_bytes);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: write buffer holding pending write-through stores.
//   clk, rst_n           - clock, asynchronous active-low reset
//   i_push, i_addr,
//   i_data, i_size       - enqueue one store (ignored when full)
//   i_pop                - dequeue the head entry (ignored when empty)
//   o_head_*             - head entry fields
//   o_count/o_full/o_empty - registered occupancy and flags
//   i_cmp_line, o_match  - o_match is high when any occupied entry holds a
//                          store to line i_cmp_line
module wb_fifo
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_BYTES = 64,
  parameter int WB_DEPTH   = 4,
  localparam int PTR_W  = $clog2(WB_DEPTH),
  localparam int CNT_W  = PTR_W + 1,
  localparam int OFF_W  = $clog2(LINE_BYTES),
  localparam int LINE_W = line_addr_w(ADDR_WIDTH, LINE_BYTES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [1:0]            i_size,
  input  logic                  i_pop,
  output logic [ADDR_WIDTH-1:0] o_head_addr,
  output logic [DATA_WIDTH-1:0] o_head_data,
  output logic [1:0]            o_head_size,
  output logic [CNT_W-1:0]      o_count,
  output logic                  o_full,
  output logic                  o_empty,
  input  logic [LINE_W-1:0]     i_cmp_line,
  output logic                  o_match
);

  logic [ADDR_WIDTH-1:0] r_addr [WB_DEPTH];
  logic [DATA_WIDTH-1:0] r_data [WB_DEPTH];
  logic [1:0]            r_size [WB_DEPTH];
  logic [WB_DEPTH-1:0]   r_valid;
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;

  logic w_push;
  logic w_pop;
  logic w_match;

  assign o_full  = (r_count == CNT_W'(WB_DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Pointers wrap naturally because WB_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Push and pop never hit the same slot: that needs a full buffer,
      // and a full buffer refuses pushes.
      if (w_pop)  r_valid[r_rptr] <= 1'b0;
      if (w_push) r_valid[r_wptr] <= 1'b1;
    end
  end

  // Payload storage carries no reset; r_valid qualifies every use.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wptr] <= i_addr;
      r_data[r_wptr] <= i_data;
      r_size[r_wptr] <= i_size;
    end
  end

  // Parallel line compare against every occupied entry.
  always_comb begin
    w_match = 1'b0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (r_valid[i] && (r_addr[i][ADDR_WIDTH-1:OFF_W] == i_cmp_line)) w_match = 1'b1;
    end
  end

  assign o_match     = w_match;
  assign o_count     = r_count;
  assign o_head_addr = r_addr[r_rptr];
  assign o_head_data = r_data[r_rptr];
  assign o_head_size = r_size[r_rptr];

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares the single APB bridge port between cache line
// fills and buffered write-through stores. A fill never overtakes a
// buffered store to the same line.
//   clk, reset                 - clock, asynchronous active-low reset
//   fill_req/fill_addr         - line-fill request (held until fill_done)
//   fill_data/fill_done        - returned line and one-cycle completion pulse
//   wr_valid/wr_addr/wr_data/
//   wr_size/wr_ready           - store push interface into the write buffer
//   mem_transfer/mem_write/
//   mem_addr/mem_wdata/mem_size- transfer request to the bridge
//   mem_rdata/mem_rready/
//   mem_wready                 - bridge completion
//   stall                      - processor stall
//   wb_count                   - write-buffer occupancy
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_BYTES = 64,
  parameter int WB_DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fill_req,
  input  logic [ADDR_WIDTH-1:0]     fill_addr,
  output logic [LINE_BYTES*8-1:0]   fill_data,
  output logic                      fill_done,
  input  logic                      wr_valid,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [1:0]                wr_size,
  output logic                      wr_ready,
  output logic                      mem_transfer,
  output logic                      mem_write,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [1:0]                mem_size,
  input  logic [LINE_BYTES*8-1:0]   mem_rdata,
  input  logic                      mem_rready,
  input  logic                      mem_wready,
  output logic                      stall,
  output logic [$clog2(WB_DEPTH):0] wb_count
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int LINE_W = line_addr_w(ADDR_WIDTH, LINE_BYTES);
  localparam int CNT_W  = $clog2(WB_DEPTH) + 1;

  if ((WB_DEPTH < 2) || ((WB_DEPTH & (WB_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("mem_req_arbiter: WB_DEPTH must be a power of 2 and at least 2");
  end

  state_t r_state;
  state_t w_next;

  logic [LINE_BYTES*8-1:0] r_fill_data;
  logic [ADDR_WIDTH-1:0]   w_fill_line_addr;
  logic [ADDR_WIDTH-1:0]   w_head_addr;
  logic [DATA_WIDTH-1:0]   w_head_data;
  logic [1:0]              w_head_size;
  logic [CNT_W-1:0]        w_count;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_match;
  logic                    w_conflict;
  logic                    w_push;
  logic                    w_pop;

  assign w_fill_line_addr = fill_addr & ~ADDR_WIDTH'(LINE_BYTES - 1);
  assign wr_ready         = ~w_full;
  assign w_push           = wr_valid & wr_ready;
  assign w_pop            = (r_state == ST_WR_WAIT) & mem_wready;
  // Only entries already registered take part; a same-cycle push does not.
  assign w_conflict       = fill_req & w_match;

  wb_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .LINE_BYTES (LINE_BYTES),
    .WB_DEPTH   (WB_DEPTH)
  ) u_wb_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .i_push      (w_push),
    .i_addr      (wr_addr),
    .i_data      (wr_data),
    .i_size      (wr_size),
    .i_pop       (w_pop),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_head_size (w_head_size),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .i_cmp_line  (fill_addr[ADDR_WIDTH-1:OFF_W]),
    .o_match     (w_match)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        // Drain stores first when full or when the fill would overtake one.
        if (w_full || w_conflict) w_next = ST_WR_ISSUE;
        else if (fill_req)        w_next = ST_RD_ISSUE;
        else if (!w_empty)        w_next = ST_WR_ISSUE;
      end
      ST_WR_ISSUE: w_next = ST_WR_WAIT;
      ST_WR_WAIT:  if (mem_wready) w_next = ST_IDLE;
      ST_RD_ISSUE: w_next = ST_RD_WAIT;
      ST_RD_WAIT:  if (mem_rready) w_next = ST_FILL_RSP;
      ST_FILL_RSP: w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mem_transfer = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_size     = '0;
    fill_done    = 1'b0;
    case (r_state)
      ST_WR_ISSUE, ST_WR_WAIT: begin
        mem_transfer = (r_state == ST_WR_ISSUE);
        mem_write    = 1'b1;
        mem_addr     = w_head_addr;
        mem_wdata    = w_head_data;
        mem_size     = w_head_size;
      end
      ST_RD_ISSUE, ST_RD_WAIT: begin
        mem_transfer = (r_state == ST_RD_ISSUE);
        mem_addr     = w_fill_line_addr;
        mem_size     = SZ_LINE;
      end
      ST_FILL_RSP: fill_done = 1'b1;
      default: ;
    endcase
  end

  // Fill data capture; holds its value after fill_done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                r_fill_data <= '0;
    else if (r_state == ST_RD_WAIT && mem_rready) r_fill_data <= mem_rdata;
  end

  assign fill_data = r_fill_data;
  assign wb_count  = w_count;
  // Gated by reset so every output except wr_ready reads 0 while reset is held.
  assign stall     = reset & ((fill_req & ~fill_done) | (wr_valid & ~wr_ready));

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed self-checking bench for mem_req_arbiter with
// a bridge model and a transfer scoreboard.
module tb_mem_req_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         fill_req;
  logic [31:0]  fill_addr;
  logic [511:0] fill_data;
  logic         fill_done;
  logic         wr_valid;
  logic [31:0]  wr_addr;
  logic [31:0]  wr_data;
  logic [1:0]   wr_size;
  logic         wr_ready;
  logic         mem_transfer;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [1:0]   mem_size;
  logic [511:0] mem_rdata;
  logic         mem_rready;
  logic         mem_wready;
  logic         stall;
  logic [2:0]   wb_count;

  mem_req_arbiter #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .LINE_BYTES (64),
    .WB_DEPTH   (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fill_req     (fill_req),
    .fill_addr    (fill_addr),
    .fill_data    (fill_data),
    .fill_done    (fill_done),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_size      (wr_size),
    .wr_ready     (wr_ready),
    .mem_transfer (mem_transfer),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_size     (mem_size),
    .mem_rdata    (mem_rdata),
    .mem_rready   (mem_rready),
    .mem_wready   (mem_wready),
    .stall        (stall),
    .wb_count     (wb_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } xfer_t;

  xfer_t exp_q[$];
  int    n_pass  = 0;
  int    n_total = 0;

  // Bridge model controls, written only by the main sequence.
  int   br_delay    = 1;
  logic hold_wr     = 1'b0;
  logic inj_rready  = 1'b0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    xfer_t e;
    e.wr = 1'b1; e.addr = a; e.data = d; e.size = s;
    exp_q.push_back(e);
  endtask

  task automatic exp_rd(input logic [31:0] a);
    xfer_t e;
    e.wr = 1'b0; e.addr = a; e.data = '0; e.size = 2'b11;
    exp_q.push_back(e);
  endtask

  // Main-sequence sampling/driving point: just after the falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Drives one store and waits (bounded) until it is accepted.
  task automatic push(input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_size = 2'b10;
    while (!wr_ready && n < 50) begin
      tick();
      n++;
    end
    check("push_accept", wr_ready, 1'b1);
    exp_wr(a, d, 2'b10);
    tick();
  endtask

  task automatic start_fill(input logic [31:0] a, input logic [511:0] pat);
    mem_rdata = pat;
    exp_rd(a & 32'hFFFF_FFC0);
    fill_req  = 1'b1;
    fill_addr = a;
  endtask

  task automatic wait_fill(input string tag, input logic [511:0] pat, input int lat);
    int n;
    n = 0;
    tick();
    check({tag, "_stall_busy"}, stall, 1'b1);
    n = 1;
    while (!fill_done && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_done"}, fill_done, 1'b1);
    check({tag, "_latency"}, n, lat);
    check({tag, "_data"}, fill_data, pat);
    check({tag, "_stall_at_done"}, stall, 1'b0);
    fill_req = 1'b0;
    tick();
    check({tag, "_done_single"}, fill_done, 1'b0);
    check({tag, "_stall_after"}, stall, 1'b0);
    check({tag, "_data_held"}, fill_data, pat);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || wb_count != 0) && n < 200) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check({tag, "_pending"}, exp_q.size(), 0);
    check({tag, "_wb_empty"}, wb_count, 3'd0);
  endtask

  // Bridge model: completes each transfer br_delay cycles after the pulse.
  initial begin : bridge
    logic busy, bwr, r, w;
    int   cnt;
    busy = 1'b0; bwr = 1'b0; cnt = 0;
    mem_rready = 1'b0;
    mem_wready = 1'b0;
    forever begin
      @(negedge clk);
      r = 1'b0;
      w = 1'b0;
      if (!reset) begin
        busy = 1'b0;
      end else begin
        if (busy) begin
          if (cnt > 1) cnt--;
          else if (!(bwr && hold_wr)) begin
            if (bwr) w = 1'b1;
            else     r = 1'b1;
            busy = 1'b0;
          end
        end
        if (mem_transfer) begin
          busy = 1'b1;
          bwr  = mem_write;
          cnt  = br_delay;
        end
      end
      mem_rready = r | inj_rready;
      mem_wready = w;
    end
  end

  // Transfer scoreboard.
  always @(negedge clk) begin
    xfer_t e;
    if (reset && mem_transfer) begin
      if (exp_q.size() == 0) begin
        check("unexpected_xfer", mem_addr, 32'hDEAD_BEEF);
      end else begin
        e = exp_q.pop_front();
        check("xfer_write", mem_write, e.wr);
        check("xfer_addr", mem_addr, e.addr);
        check("xfer_size", mem_size, e.size);
        if (e.wr) check("xfer_wdata", mem_wdata, e.data);
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    logic [511:0] pat1, pat2, pat3, pat4, pat5;
    pat1 = {16{32'hCAFE_0001}};
    pat2 = {16{32'h1234_5678}};
    pat3 = {16{32'hDEAD_0003}};
    pat4 = {16{32'h0BAD_F00D}};
    pat5 = {8{64'h0123_4567_89AB_CDEF}};

    reset = 1'b0; fill_req = 1'b0; fill_addr = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_size = '0; mem_rdata = '0;
    repeat (3) tick();
    check("rst_wr_ready", wr_ready, 1'b1);
    check("rst_wb_count", wb_count, 3'd0);
    check("rst_transfer", mem_transfer, 1'b0);
    check("rst_fill_done", fill_done, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_fill_data", fill_data, 512'd0);
    reset = 1'b1;
    tick();

    // Fill with empty buffer, bridge answers 3 cycles after the pulse.
    br_delay = 3;
    start_fill(32'h0000_0044, pat1);
    wait_fill("fill1", pat1, 5);
    drain("fill1");

    // Store drain in push order.
    br_delay = 1;
    push(32'h100, 32'h1111_0000);
    push(32'h104, 32'h2222_0000);
    push(32'h108, 32'h3333_0000);
    wr_valid = 1'b0;
    check("drain_wb_count3", wb_count, 3'd3);
    drain("drain");

    // Conflict: buffered store to line 0x80 must be written before the fill.
    wr_valid = 1'b1; wr_addr = 32'h84; wr_data = 32'hC0FF_EE84; wr_size = 2'b10;
    check("conf_push_ready", wr_ready, 1'b1);
    exp_wr(32'h84, 32'hC0FF_EE84, 2'b10);
    tick();
    wr_valid = 1'b0;
    start_fill(32'h80, pat2);
    wait_fill("conf", pat2, 6);
    drain("conf");

    // No conflict: different line, the read goes first.
    wr_valid = 1'b1; wr_addr = 32'h200; wr_data = 32'h0000_0200; wr_size = 2'b10;
    check("noconf_push_ready", wr_ready, 1'b1);
    tick();
    wr_valid = 1'b0;
    start_fill(32'h80, pat5);
    exp_wr(32'h200, 32'h0000_0200, 2'b10);
    wait_fill("noconf", pat5, 3);
    drain("noconf");

    // Full buffer, back-pressure, then wrap across 8 stores.
    hold_wr = 1'b1;
    for (int i = 0; i < 4; i++) push(32'h300 + 32'(4 * i), 32'hF000_0000 + 32'(i));
    check("full_wr_ready", wr_ready, 1'b0);
    check("full_wb_count", wb_count, 3'd4);
    wr_valid = 1'b1; wr_addr = 32'h310; wr_data = 32'hF000_0004; wr_size = 2'b10;
    tick();
    check("full_stall", stall, 1'b1);
    tick();
    check("full_not_accepted", wb_count, 3'd4);
    hold_wr = 1'b0;
    for (int i = 4; i < 8; i++) push(32'h300 + 32'(4 * i), 32'hF000_0000 + 32'(i));
    wr_valid = 1'b0;
    drain("full");

    // Push and pop in the same cycle.
    hold_wr = 1'b1;
    push(32'h400, 32'hAAAA_0400);
    wr_valid = 1'b0;
    repeat (3) tick();
    check("simul_count1", wb_count, 3'd1);
    hold_wr = 1'b0;
    tick();
    wr_valid = 1'b1; wr_addr = 32'h404; wr_data = 32'hBBBB_0404; wr_size = 2'b10;
    exp_wr(32'h404, 32'hBBBB_0404, 2'b10);
    tick();
    wr_valid = 1'b0;
    check("simul_count_same", wb_count, 3'd1);
    drain("simul");

    // Reset while waiting for read data.
    br_delay = 10;
    start_fill(32'h540, pat3);
    repeat (4) tick();
    check("rstmid_rd_issued", exp_q.size(), 0);
    reset = 1'b0;
    #1;
    check("rstmid_transfer", mem_transfer, 1'b0);
    check("rstmid_addr", mem_addr, 32'd0);
    check("rstmid_size", mem_size, 2'd0);
    check("rstmid_stall", stall, 1'b0);
    check("rstmid_wb_count", wb_count, 3'd0);
    check("rstmid_wr_ready", wr_ready, 1'b1);
    check("rstmid_fill_data", fill_data, 512'd0);
    tick();
    fill_req = 1'b0;
    reset    = 1'b1;
    br_delay = 1;
    tick();
    inj_rready = 1'b1;
    tick();
    inj_rready = 1'b0;
    tick();
    check("stale_rready_done", fill_done, 1'b0);
    check("stale_rready_data", fill_data, 512'd0);
    start_fill(32'h5C4, pat4);
    wait_fill("postrst", pat4, 3);
    drain("postrst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
